// File: rtl/tone_generator_if.sv
// rtl/tone_generator_if.sv - control and output signals of the buzzer tone generator
interface tone_generator_if;
  logic        enable;
  logic [14:0] frequency;
  logic        speaker;
  logic        active;
  logic        periodTick;

  modport master (
    output enable,
    output frequency,
    input  speaker,
    input  active,
    input  periodTick
  );

  modport slave (
    input  enable,
    input  frequency,
    output speaker,
    output active,
    output periodTick
  );
endinterface

// File: rtl/tone_generator.sv
// rtl/tone_generator.sv - glitch-free square-wave buzzer driver, 2*halfReg cycle period
module tone_generator (
  input  logic           clk,
  input  logic           rst_n,
  tone_generator_if.slave tone
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t      state;
  logic [14:0] halfReg;
  logic [14:0] cnt;
  logic        start;
  logic        phase_done;

  // A new period may only begin from IDLE or at the very end of LOW, so the
  // frequency is never sampled mid-period.
  assign start      = tone.enable && (tone.frequency != 15'd0);
  assign phase_done = (cnt == halfReg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      halfReg         <= 15'd0;
      cnt             <= 15'd0;
      tone.speaker    <= 1'b0;
      tone.active     <= 1'b0;
      tone.periodTick <= 1'b0;
    end else begin
      tone.periodTick <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            halfReg         <= tone.frequency;
            cnt             <= 15'd1;
            state           <= HIGH;
            tone.speaker    <= 1'b1;
            tone.active     <= 1'b1;
            tone.periodTick <= 1'b1;
          end
        end

        HIGH: begin
          if (phase_done) begin
            cnt          <= 15'd1;
            state        <= LOW;
            tone.speaker <= 1'b0;
          end else begin
            cnt <= cnt + 15'd1;
          end
        end

        LOW: begin
          if (!phase_done) begin
            cnt <= cnt + 15'd1;
          end else if (start) begin
            halfReg         <= tone.frequency;
            cnt             <= 15'd1;
            state           <= HIGH;
            tone.speaker    <= 1'b1;
            tone.periodTick <= 1'b1;
          end else begin
            cnt         <= 15'd0;
            state       <= IDLE;
            tone.active <= 1'b0;
          end
        end

        default: begin
          state           <= IDLE;
          cnt             <= 15'd0;
          tone.speaker    <= 1'b0;
          tone.active     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/tone_generator.md
TONE_GENERATOR -- requirements
Module: tone_generator

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 enable  input  1  level; 1 = tone requested.
REQ-004 frequency  input  15  half-period length in clk cycles (e.g. 25000 -> 1 kHz at 50 MHz); 0 = silence.
REQ-005 speaker  output  1  registered square wave to the buzzer.
REQ-006 active  output  1  registered; 1 while a period is in progress (HIGH or LOW state).
REQ-007 periodTick  output  1  registered one-cycle pulse on each speaker rising edge.

Function
REQ-008 The FSM SHALL have exactly three states: IDLE, HIGH, LOW; speaker = 1 only in HIGH.
REQ-009 The block SHALL hold a 15-bit latched half-period register halfReg and a 15-bit counter cnt.
REQ-010 IDLE: if enable=1 and frequency!=0, the block SHALL latch halfReg<=frequency and set cnt<=1, and SHALL enter HIGH next cycle with speaker=1 and periodTick=1; otherwise it SHALL stay in IDLE.
REQ-011 Latency: from the edge sampling enable=1 in IDLE to speaker=1 SHALL be exactly 1 cycle.
REQ-012 HIGH: if cnt==halfReg, the block SHALL enter LOW with cnt<=1; otherwise cnt<=cnt+1.
REQ-013 LOW: if cnt!=halfReg, the block SHALL set cnt<=cnt+1.
REQ-014 LOW, cnt==halfReg, enable=1 and frequency!=0: the block SHALL re-latch halfReg<=frequency, set cnt<=1, enter HIGH and pulse periodTick.
REQ-015 LOW, cnt==halfReg, enable=0 or frequency==0: the block SHALL enter IDLE with cnt<=0.
REQ-016 Each HIGH and each LOW phase SHALL last exactly halfReg cycles, so the period is 2*halfReg cycles.
REQ-017 frequency changes SHALL be sampled only in IDLE or at the end of LOW; mid-period changes SHALL NOT alter the current period (glitch-free).
REQ-018 enable deassert during HIGH or LOW SHALL NOT truncate the period; the current HIGH and LOW SHALL complete before IDLE.
REQ-019 frequency=1 SHALL give 1 cycle high and 1 cycle low, continuously.
REQ-020 frequency=0x7FFF SHALL count without overflow; cnt never exceeds halfReg.
REQ-021 active SHALL be 1 in HIGH and LOW and 0 in IDLE, registered with the state.
REQ-022 periodTick SHALL be 0 in every cycle except the first cycle of each HIGH phase.

Reset
REQ-023 When rst_n=0, the block SHALL immediately force state=IDLE, speaker=0, active=0, periodTick=0, cnt=0 and halfReg=0, asynchronously and regardless of clk.
REQ-024 After rst_n rises, the first tone SHALL start per REQ-010; no partial period resumes.
REQ-025 Reset asserted mid-HIGH SHALL drop speaker to 0 within the same cycle, without waiting for a clock edge.

Verification
REQ-026 enable=1, frequency=6250 held -> speaker 1 for 6250 cycles, 0 for 6250 cycles, repeating; periodTick every 12500 cycles; first high 1 cycle after enable.
REQ-027 frequency=25000, changed to 12500 mid-HIGH -> current high 25000 and low 25000 cycles; next period 12500/12500.
REQ-028 frequency=8333, enable dropped at cycle 100 of HIGH -> HIGH completes 8333, LOW 8333, then IDLE with speaker=0 and active=0; no further periodTick.
REQ-029 enable=1, frequency=0 -> speaker, active and periodTick stay 0 indefinitely; frequency then set to 30000 -> speaker high on the next cycle.
REQ-030 frequency=1, enable=1 -> speaker toggles every cycle and periodTick fires every 2 cycles; async rst_n low mid-stream -> all outputs 0 before the next clk edge.
